seq_counter_prog: RTL and testbench

- Parametrised successor to the fixed 5-state up/down sequence counter.
- Steps through a programmable table of DEPTH arbitrary WIDTH-bit codes. Modes: up, down, hold/ping-pong, and direct index load.
- The table is run-time writable; wrap and error pulses are provided for downstream control logic.
- Used wherever the design needs a non-binary code sequence whose contents change without re-synthesis.

---
 rtl/seq_counter_prog.sv | 147 ++++++++++++++
 tb/tb_seq_counter_prog.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/seq_counter_prog.sv
// seq_counter_prog: programmable sequence counter.
// Steps through a run-time writable table of DEPTH codes, each WIDTH bits wide.
// Modes: 00 up, 01 down, 10 hold, 11 load index.
// Optional macro SEQCNT_PINGPONG_EN turns mode 10 into ping-pong. It adds an
// internal direction register, which resets to up.
// All outputs are registered. There is no combinational path from input to
// output.
module seq_counter_prog #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 5,
    parameter int IDXW  = 3,
    parameter logic [DEPTH*WIDTH-1:0] INIT = 25'b10000_10101_00011_01000_00001
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [IDXW-1:0]  ld_idx,
    input  logic             wr_en,
    input  logic [IDXW-1:0]  wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] counter,
    output logic [IDXW-1:0]  idx,
    output logic             wrap,
    output logic             err
);

    localparam logic [IDXW-1:0] LAST    = IDXW'(DEPTH - 1);
    localparam logic [IDXW-1:0] ONE     = IDXW'(1);
    localparam logic [IDXW:0]   DEPTH_X = (IDXW+1)'(DEPTH);

    // Only DEPTH entries exist. Addresses at or above DEPTH are never stored.
    logic [WIDTH-1:0] tbl [DEPTH];

    logic [IDXW-1:0]  idx_n;
    logic             wrap_n;
    logic             err_n;
    logic [WIDTH-1:0] cnt_n;
    logic             ld_ok;
    logic             wr_ok;

    assign ld_ok = ({1'b0, ld_idx} < DEPTH_X);
    assign wr_ok = wr_en && ({1'b0, wr_addr} < DEPTH_X);

`ifdef SEQCNT_PINGPONG_EN
    localparam logic [IDXW-1:0] LAST_M1 = IDXW'(DEPTH - 2);
    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;
    logic dir;
    logic dir_n;
`endif

    // State register: index, pulses, direction and the table itself.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx     <= '0;
            wrap    <= 1'b0;
            err     <= 1'b0;
            counter <= INIT[WIDTH-1:0];
            for (int i = 0; i < DEPTH; i++) begin
                tbl[i] <= INIT[i*WIDTH +: WIDTH];
            end
`ifdef SEQCNT_PINGPONG_EN
            dir <= DIR_UP;
`endif
        end else begin
            idx     <= idx_n;
            wrap    <= wrap_n;
            err     <= err_n;
            counter <= cnt_n;
            if (wr_ok) begin
                tbl[wr_addr] <= wr_data;
            end
`ifdef SEQCNT_PINGPONG_EN
            dir <= dir_n;
`endif
        end
    end

    // Next-state: choose the next index and the wrap/err pulses from mode and en.
    always_comb begin
        idx_n  = idx;
        wrap_n = 1'b0;
        err_n  = 1'b0;
`ifdef SEQCNT_PINGPONG_EN
        dir_n  = dir;
`endif
        if (en) begin
            case (mode)
                2'b00: begin
                    if (idx == LAST) begin
                        idx_n  = '0;
                        wrap_n = 1'b1;
                    end else begin
                        idx_n = idx + ONE;
                    end
                end
                2'b01: begin
                    if (idx == '0) begin
                        idx_n  = LAST;
                        wrap_n = 1'b1;
                    end else begin
                        idx_n = idx - ONE;
                    end
                end
                2'b10: begin
`ifdef SEQCNT_PINGPONG_EN
                    // Bounce at either end. This mode never raises wrap.
                    if (dir == DIR_UP) begin
                        if (idx == LAST) begin
                            dir_n = DIR_DOWN;
                            idx_n = LAST_M1;
                        end else begin
                            idx_n = idx + ONE;
                        end
                    end else begin
                        if (idx == '0) begin
                            dir_n = DIR_UP;
                            idx_n = ONE;
                        end else begin
                            idx_n = idx - ONE;
                        end
                    end
`else
                    idx_n = idx;
`endif
                end
                default: begin
                    if (ld_ok) begin
                        idx_n = ld_idx;
                    end else begin
                        err_n = 1'b1;
                    end
                end
            endcase
        end
    end

    // Output: next code, with a same-cycle write to the target entry forwarded.
    always_comb begin
        cnt_n = tbl[idx_n];
        if (wr_ok && (wr_addr == idx_n)) begin
            cnt_n = wr_data;
        end
    end

endmodule

// File: tb/tb_seq_counter_prog.sv
// tb_seq_counter_prog: directed scenarios plus randomized stimulus.
// Expected values come from a behavioural model of the sequence table.
module tb_seq_counter_prog;
    localparam int WIDTH = 5;
    localparam int DEPTH = 5;
    localparam int IDXW  = 3;
    localparam logic [DEPTH*WIDTH-1:0] INIT = 25'b10000_10101_00011_01000_00001;

    logic             clk;
    logic             rst;
    logic             en;
    logic [1:0]       mode;
    logic [IDXW-1:0]  ld_idx;
    logic             wr_en;
    logic [IDXW-1:0]  wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic [WIDTH-1:0] counter;
    logic [IDXW-1:0]  idx;
    logic             wrap;
    logic             err;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model state.
    int m_tbl [DEPTH];
    int m_idx;
    int m_dir_up;
    int e_counter, e_wrap, e_err;

    seq_counter_prog #(.WIDTH(WIDTH), .DEPTH(DEPTH), .IDXW(IDXW), .INIT(INIT)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .ld_idx(ld_idx),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .counter(counter), .idx(idx), .wrap(wrap), .err(err)
    );

    // Clock and reset block.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int init_entry(input int i);
        logic [DEPTH*WIDTH-1:0] v;
        v = INIT;
        return int'(v[i*WIDTH +: WIDTH]);
    endfunction

    // Model one clock edge from the current input values.
    task automatic model_edge();
        int ni;
        e_wrap = 0;
        e_err  = 0;
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) m_tbl[i] = init_entry(i);
            m_idx = 0;
            m_dir_up = 1;
            e_counter = m_tbl[0];
            return;
        end
        ni = m_idx;
        if (en) begin
            case (mode)
                2'd0: begin ni = (m_idx + 1) % DEPTH; e_wrap = (m_idx == DEPTH-1); end
                2'd1: begin ni = (m_idx + DEPTH - 1) % DEPTH; e_wrap = (m_idx == 0); end
                2'd2: begin
`ifdef SEQCNT_PINGPONG_EN
                    if (m_dir_up != 0) begin
                        if (m_idx == DEPTH-1) begin m_dir_up = 0; ni = DEPTH-2; end
                        else ni = m_idx + 1;
                    end else begin
                        if (m_idx == 0) begin m_dir_up = 1; ni = 1; end
                        else ni = m_idx - 1;
                    end
`endif
                end
                default: begin
                    if (int'(ld_idx) < DEPTH) ni = int'(ld_idx);
                    else e_err = 1;
                end
            endcase
        end
        if (wr_en && int'(wr_addr) < DEPTH) m_tbl[wr_addr] = int'(wr_data);
        m_idx = ni;
        e_counter = m_tbl[ni];
    endtask

    // Driver: apply inputs, clock one edge, update model, compare #1 later.
    task automatic step(input logic r, input logic e, input logic [1:0] m,
                        input int li, input logic we, input int wa, input int wd);
        rst = r; en = e; mode = m; ld_idx = IDXW'(li);
        wr_en = we; wr_addr = IDXW'(wa); wr_data = WIDTH'(wd);
        @(posedge clk);
        model_edge();
        #1;
        check("model_counter", int'(counter), e_counter);
        check("model_idx", int'(idx), m_idx);
        check("model_wrap", int'(wrap), e_wrap);
        check("model_err", int'(err), e_err);
    endtask

    initial begin : main
        int exp_up [6];
        int exp_wr [6];
        int exp_pp [9];
        exp_up = '{8, 3, 21, 16, 1, 8};
        exp_wr = '{0, 0, 0, 0, 1, 0};
`ifdef SEQCNT_PINGPONG_EN
        exp_pp = '{1, 2, 3, 4, 3, 2, 1, 0, 1};
`else
        exp_pp = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
`endif
        rst = 1'b1; en = 1'b0; mode = 2'b00; ld_idx = '0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        m_idx = 0; m_dir_up = 1; e_counter = 0; e_wrap = 0; e_err = 0;

        // Reset state.
        step(1, 0, 0, 0, 0, 0, 0);
        check("reset_counter", int'(counter), 1);
        check("reset_idx", int'(idx), 0);
        check("reset_wrap", int'(wrap), 0);
        check("reset_err", int'(err), 0);

        // Count up through the default sequence.
        for (int i = 0; i < 6; i++) begin
            step(0, 1, 2'b00, 0, 0, 0, 0);
            check("up_counter", int'(counter), exp_up[i]);
            check("up_wrap", int'(wrap), exp_wr[i]);
        end

        // Count down from reset.
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 1, 2'b01, 0, 0, 0, 0);
        check("down_counter0", int'(counter), 16);
        check("down_idx0", int'(idx), 4);
        check("down_wrap0", int'(wrap), 1);
        step(0, 1, 2'b01, 0, 0, 0, 0);
        check("down_counter1", int'(counter), 21);
        check("down_wrap1", int'(wrap), 0);

        // Legal load, illegal load, then disabled.
        step(0, 1, 2'b11, 3, 0, 0, 0);
        check("ld_counter", int'(counter), 21);
        check("ld_idx", int'(idx), 3);
        check("ld_err", int'(err), 0);
        step(0, 1, 2'b11, 6, 0, 0, 0);
        check("badld_idx", int'(idx), 3);
        check("badld_counter", int'(counter), 21);
        check("badld_err", int'(err), 1);
        step(0, 0, 2'b00, 0, 0, 0, 0);
        check("en0_idx", int'(idx), 3);
        check("en0_err", int'(err), 0);
        check("en0_wrap", int'(wrap), 0);

        // Write-through on the step edge, then an out-of-range write.
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 1, 2'b00, 0, 1, 1, 31);
        check("wt_counter", int'(counter), 31);
        check("wt_idx", int'(idx), 1);
        step(0, 0, 2'b00, 0, 1, 7, 5);
        check("oob_counter", int'(counter), 31);

        // Reset mid-sequence drops the written entry.
        step(0, 1, 2'b11, 3, 0, 0, 0);
        step(1, 1, 2'b00, 0, 0, 0, 0);
        check("midrst_counter", int'(counter), 1);
        check("midrst_idx", int'(idx), 0);
        check("midrst_wrap", int'(wrap), 0);
        step(0, 1, 2'b00, 0, 0, 0, 0);
        check("midrst_entry1", int'(counter), 8);

        // Mode 10 from reset.
        step(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 9; i++) begin
            step(0, 1, 2'b10, 0, 0, 0, 0);
            check("pp_idx", int'(idx), exp_pp[i]);
            check("pp_wrap", int'(wrap), 0);
        end

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
                 2'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
                 ($urandom_range(0, 3) == 0), int'($urandom_range(0, 7)),
                 int'($urandom_range(0, 31)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
